// File: rtl/wb_mem_arbiter.sv
// Two-master (I-cache, D-cache) to one-slave Wishbone line arbiter with a one-cycle release turnaround.
// Optional build macro ARB_ROUND_ROBIN_EN: round-robin tie-break; otherwise D wins every tie.
module wb_mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 128,
  parameter int SEL_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cyc,
  input  logic              i_stb,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_adr,
  input  logic [DATA_W-1:0] i_dat_m,
  input  logic [SEL_W-1:0]  i_sel,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_dat_s,
  input  logic              d_cyc,
  input  logic              d_stb,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_adr,
  input  logic [DATA_W-1:0] d_dat_m,
  input  logic [SEL_W-1:0]  d_sel,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_dat_s,
  output logic              m_cyc,
  output logic              m_stb,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_adr,
  output logic [DATA_W-1:0] m_dat_m,
  output logic [SEL_W-1:0]  m_sel,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_dat_s
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GNT_I   = 2'd1;
  localparam logic [1:0] ST_GNT_D   = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  logic [1:0] state, state_nxt;
  logic       req_i, req_d;
  logic       pick_d;

  assign req_i = i_cyc & i_stb;
  assign req_d = d_cyc & d_stb;

`ifdef ARB_ROUND_ROBIN_EN
  // last_gnt: 0 = I, 1 = D; only consulted on a tie
  logic last_gnt;

  assign pick_d = req_d & (~req_i | ~last_gnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= 1'b0;
    end else if (state == ST_IDLE && (req_i || req_d)) begin
      last_gnt <= pick_d;
    end
  end
`else
  assign pick_d = req_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (pick_d)     state_nxt = ST_GNT_D;
        else if (req_i) state_nxt = ST_GNT_I;
      end
      ST_GNT_I:   if (m_ack || !i_cyc) state_nxt = ST_RELEASE;
      ST_GNT_D:   if (m_ack || !d_cyc) state_nxt = ST_RELEASE;
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decode straight from state so a reset drops m_cyc without waiting for a clock
  always_comb begin
    m_cyc   = 1'b0;
    m_stb   = 1'b0;
    m_we    = 1'b0;
    m_adr   = '0;
    m_dat_m = '0;
    m_sel   = '0;
    i_ack   = 1'b0;
    d_ack   = 1'b0;
    case (state)
      ST_GNT_I: begin
        m_cyc   = i_cyc;
        m_stb   = i_stb;
        m_we    = i_we;
        m_adr   = i_adr;
        m_dat_m = i_dat_m;
        m_sel   = i_sel;
        i_ack   = m_ack & i_cyc;
      end
      ST_GNT_D: begin
        m_cyc   = d_cyc;
        m_stb   = d_stb;
        m_we    = d_we;
        m_adr   = d_adr;
        m_dat_m = d_dat_m;
        m_sel   = d_sel;
        d_ack   = m_ack & d_cyc;
      end
      default: ;
    endcase
  end

  assign i_dat_s = m_dat_s;
  assign d_dat_s = m_dat_s;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter; tie-break expectations follow ARB_ROUND_ROBIN_EN.
module tb_wb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_cyc, i_stb, i_we, i_ack;
  logic [11:0]  i_adr;
  logic [127:0] i_dat_m, i_dat_s;
  logic [15:0]  i_sel;
  logic         d_cyc, d_stb, d_we, d_ack;
  logic [11:0]  d_adr;
  logic [127:0] d_dat_m, d_dat_s;
  logic [15:0]  d_sel;
  logic         m_cyc, m_stb, m_we, m_ack;
  logic [11:0]  m_adr;
  logic [127:0] m_dat_m, m_dat_s;
  logic [15:0]  m_sel;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [127:0] RD_DAT = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [127:0] WR_DAT = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  always #5 clk = ~clk;

  wb_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr), .i_dat_m(i_dat_m),
    .i_sel(i_sel), .i_ack(i_ack), .i_dat_s(i_dat_s),
    .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr), .d_dat_m(d_dat_m),
    .d_sel(d_sel), .d_ack(d_ack), .d_dat_s(d_dat_s),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_m(m_dat_m),
    .m_sel(m_sel), .m_ack(m_ack), .m_dat_s(m_dat_s)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    i_cyc = 0; i_stb = 0; i_we = 0; i_adr = '0; i_dat_m = '0; i_sel = '0;
    d_cyc = 0; d_stb = 0; d_we = 0; d_adr = '0; d_dat_m = '0; d_sel = '0;
    m_ack = 0;
  endtask

  initial begin
    idle_all();
    m_dat_s = '0;
    rst = 1'b1;
    #1;
    chk("rst_m_cyc", m_cyc, 0);
    chk("rst_acks", {i_ack, d_ack}, 0);
    chk("rst_m_adr", m_adr, 0);
    step(); step();
    rst = 1'b0;
    step();

    // 1: single I read
    i_cyc = 1; i_stb = 1; i_adr = 12'h0A3;
    #1 chk("t1_idle_no_cyc", m_cyc, 0);
    step();
    chk("t1_m_cyc", m_cyc, 1);
    chk("t1_m_adr", m_adr, 12'h0A3);
    chk("t1_m_we", m_we, 0);
    step(); step();
    chk("t1_no_ack_yet", i_ack, 0);
    m_ack = 1; m_dat_s = RD_DAT;
    #1;
    chk("t1_i_ack", i_ack, 1);
    chk("t1_i_dat_s", i_dat_s, RD_DAT);
    chk("t1_d_ack", d_ack, 0);
    step();
    m_ack = 0;
    #1;
    chk("t1_rel_m_cyc", m_cyc, 0);
    chk("t1_rel_i_ack", i_ack, 0);
    idle_all();
    step();

    // 2: simultaneous I+D, D keeps re-requesting
    i_cyc = 1; i_stb = 1; i_adr = 12'h111;
    d_cyc = 1; d_stb = 1; d_adr = 12'h222;
    step();
    chk("t2_first_adr", m_adr, 12'h222);
    m_ack = 1;
    #1;
    chk("t2_first_d_ack", d_ack, 1);
    chk("t2_first_i_ack", i_ack, 0);
    step();
    m_ack = 0; d_adr = 12'h333;
    #1 chk("t2_rel_m_cyc", m_cyc, 0);
    step();
    chk("t2_idle_m_cyc", m_cyc, 0);
    step();
    chk("t2_second_m_cyc", m_cyc, 1);
`ifdef ARB_ROUND_ROBIN_EN
    chk("t2_second_adr", m_adr, 12'h111);
`else
    chk("t2_second_adr", m_adr, 12'h333);
`endif
    m_ack = 1;
    #1;
`ifdef ARB_ROUND_ROBIN_EN
    chk("t2_second_acks", {i_ack, d_ack}, 2'b10);
`else
    chk("t2_second_acks", {i_ack, d_ack}, 2'b01);
`endif
    step();
    idle_all();
    step();

    // 3: D write
    d_cyc = 1; d_stb = 1; d_we = 1; d_sel = 16'hFFFF; d_dat_m = WR_DAT; d_adr = 12'h5C0;
    step();
    chk("t3_m_we", m_we, 1);
    chk("t3_m_dat_m", m_dat_m, WR_DAT);
    chk("t3_m_sel", m_sel, 16'hFFFF);
    step();
    chk("t3_m_stb_hold", m_stb, 1);
    m_ack = 1;
    #1 chk("t3_d_ack", d_ack, 1);
    step();
    m_ack = 0;
    #1;
    chk("t3_rel_m_cyc", m_cyc, 0);
    chk("t3_rel_m_we", m_we, 0);
    chk("t3_rel_m_sel", m_sel, 0);
    idle_all();
    step();

    // 4: abandoned I cycle, late ack in RELEASE
    i_cyc = 1; i_stb = 1; i_adr = 12'h0F0;
    step();
    chk("t4_m_cyc", m_cyc, 1);
    i_cyc = 0; i_stb = 0;
    #1 chk("t4_drop_m_cyc", m_cyc, 0);
    step();
    m_ack = 1;
    #1 chk("t4_late_ack", {i_ack, d_ack}, 0);
    step();
    m_ack = 0;
    #1 chk("t4_idle_m_cyc", m_cyc, 0);
    step();

    // 5: reset during GNT_D
    d_cyc = 1; d_stb = 1; d_adr = 12'hABC;
    step();
    chk("t5_m_cyc", m_cyc, 1);
    rst = 1;
    #1;
    chk("t5_async_m_cyc", m_cyc, 0);
    chk("t5_async_m_adr", m_adr, 0);
    m_ack = 1;
    #1 chk("t5_rst_d_ack", d_ack, 0);
    step();
    m_ack = 0; rst = 0;
    #1 chk("t5_post_rst_idle", m_cyc, 0);
    step();
    chk("t5_regrant", m_cyc, 1);
    chk("t5_regrant_adr", m_adr, 12'hABC);
    m_ack = 1;
    #1 chk("t5_d_ack", d_ack, 1);
    step();
    idle_all();
    step();

    // 6: spurious ack in IDLE
    m_ack = 1;
    #1 chk("t6_acks", {i_ack, d_ack}, 0);
    step();
    m_ack = 0;
    i_cyc = 1; i_stb = 1; i_adr = 12'h777;
    #1 chk("t6_still_idle", m_cyc, 0);
    step();
    chk("t6_grant", m_adr, 12'h777);
    idle_all();
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
